// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode handshake and result/flag bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 8);
   logic in_valid;
   logic in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic c_in;
   logic [2:0] control_line;
   logic mode_select;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic c_out;
   logic zero;
   logic negative;
   logic overflow;
   modport master (
      output in_valid, A, B, c_in, control_line, mode_select, out_ready,
      input in_ready, out_valid, out, out_hi, c_out, zero, negative, overflow
   );
   modport slave (
      input in_valid, A, B, c_in, control_line, mode_select, out_ready,
      output in_ready, out_valid, out, out_hi, c_out, zero, negative, overflow
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered logic/arithmetic unit with status flags, valid/ready
// handshakes and a WIDTH-cycle shift-add unsigned multiplier.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input logic clk,
   input logic rst,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic accept;
   logic is_mul;
   logic [WIDTH:0] ea;
   logic [WIDTH:0] eb;
   logic [WIDTH:0] one;
   logic [WIDTH:0] cin_w;
   logic [WIDTH:0] add_s;
   logic [WIDTH:0] sub_d;
   logic [WIDTH:0] cmp_d;
   logic [WIDTH:0] step;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] flag_src;
   logic res_c;
   logic res_v;
   assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
   assign bus.out_valid = state == DONE;
   assign accept = bus.in_valid && bus.in_ready;
   assign is_mul = bus.mode_select && bus.control_line == 3'd4;
   assign ea = {1'b0, bus.A};
   assign eb = {1'b0, bus.B};
   assign one = {{WIDTH{1'b0}}, 1'b1};
   assign cin_w = {{WIDTH{1'b0}}, bus.c_in};
   assign add_s = ea + eb + cin_w;
   assign sub_d = ea - eb - cin_w;
   assign cmp_d = ea - eb;
   // {hi,lo} holds partial product over remaining multiplier bits; add then shift right
   assign step = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
   assign nxt_hi = step[WIDTH:1];
   assign nxt_lo = {step[0], lo[WIDTH-1:1]};
   always_comb begin
      res = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case ({bus.mode_select, bus.control_line})
         4'b0000: res = bus.A & bus.B;
         4'b0001: res = bus.A | bus.B;
         4'b0010: res = bus.A ^ bus.B;
         4'b0011: res = ~bus.A;
         4'b0100: res = ~(bus.A & bus.B);
         4'b0101: res = ~(bus.A | bus.B);
         4'b0110: res = ~(bus.A ^ bus.B);
         4'b0111: res = bus.B;
         4'b1000: begin
            {res_c, res} = add_s;
            res_v = bus.A[WIDTH-1] == bus.B[WIDTH-1] && add_s[WIDTH-1] != bus.A[WIDTH-1];
         end
         4'b1001: begin
            {res_c, res} = sub_d;
            res_v = bus.A[WIDTH-1] != bus.B[WIDTH-1] && sub_d[WIDTH-1] != bus.A[WIDTH-1];
         end
         4'b1010: {res_c, res} = ea + one;
         4'b1011: {res_c, res} = ea - one;
         4'b1100: res = '0;
         4'b1101: {res_c, res} = {bus.A, 1'b0};
         4'b1110: {res, res_c} = {1'b0, bus.A};
         4'b1111: begin
            res = bus.A;
            res_c = cmp_d[WIDTH];
            res_v = bus.A[WIDTH-1] != bus.B[WIDTH-1] && cmp_d[WIDTH-1] != bus.A[WIDTH-1];
         end
      endcase
      flag_src = {bus.mode_select, bus.control_line} == 4'b1111 ? cmp_d[WIDTH-1:0] : res;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         mcand <= '0;
         hi <= '0;
         lo <= '0;
         bus.out <= '0;
         bus.out_hi <= '0;
         bus.c_out <= 1'b0;
         bus.zero <= 1'b0;
         bus.negative <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept && is_mul) begin
                  state <= BUSY;
                  cnt <= '0;
                  mcand <= bus.A;
                  hi <= '0;
                  lo <= bus.B;
               end else if (accept) begin
                  state <= DONE;
                  bus.out <= res;
                  bus.out_hi <= '0;
                  bus.c_out <= res_c;
                  bus.zero <= flag_src == '0;
                  bus.negative <= flag_src[WIDTH-1];
                  bus.overflow <= res_v;
               end else if (state == DONE && bus.out_ready) begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               hi <= nxt_hi;
               lo <= nxt_lo;
               if (cnt == LAST) begin
                  state <= DONE;
                  bus.out <= nxt_lo;
                  bus.out_hi <= nxt_hi;
                  bus.c_out <= |nxt_hi;
                  bus.zero <= nxt_lo == '0;
                  bus.negative <= nxt_lo[WIDTH-1];
                  bus.overflow <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
